// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the 1x3 router controller
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int NUM_PORTS = 3;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - packet sequencing controller for the 1x3 router register stage
module router_fsm
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              packet_valid,
    input  logic [ADDR_W-1:0] datain,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic              empty_sel;
    logic              soft_reset_sel;
    logic              header_ok;

    // While decoding, the header on datain is the port under test; afterwards the latched addr is.
    assign sel_addr  = (state == DECODE_ADDRESS) ? datain : addr;
    assign header_ok = packet_valid && (datain != ADDR_INVALID);

    always_comb begin
        empty_sel = 1'b0;
        case (sel_addr)
            2'd0:    empty_sel = fifo_empty_0;
            2'd1:    empty_sel = fifo_empty_1;
            2'd2:    empty_sel = fifo_empty_2;
            default: empty_sel = 1'b0;
        endcase
    end

    always_comb begin
        soft_reset_sel = 1'b0;
        case (addr)
            2'd0:    soft_reset_sel = soft_reset_0;
            2'd1:    soft_reset_sel = soft_reset_1;
            2'd2:    soft_reset_sel = soft_reset_2;
            default: soft_reset_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DECODE_ADDRESS;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        case (state)
            DECODE_ADDRESS: begin
                if (header_ok) begin
                    addr_nxt  = datain;
                    state_nxt = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_nxt = FIFO_FULL_STATE;
                else if (!packet_valid)
                    state_nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_nxt = DECODE_ADDRESS;
                else if (low_packet_valid)
                    state_nxt = LOAD_PARITY;
                else
                    state_nxt = LOAD_DATA;
            end
            LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (empty_sel)
                    state_nxt = LOAD_FIRST_DATA;
            end
            default: state_nxt = DECODE_ADDRESS;
        endcase
        // A timeout on the selected port abandons the packet from any in-flight state.
        if (state != DECODE_ADDRESS && soft_reset_sel)
            state_nxt = DECODE_ADDRESS;
    end

    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        full_state    = (state == FIFO_FULL_STATE);
        laf_state     = (state == LOAD_AFTER_FULL);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_FIRST_DATA) || (state == LOAD_DATA) ||
                        (state == LOAD_AFTER_FULL) || (state == LOAD_PARITY);
        busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    end

endmodule
